// File: rtl/punc_pkg.sv
// rtl/punc_pkg.sv - opcode, state and select encodings shared by the punc control unit
package punc_pkg;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_RTI = 4'b1000;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_HLT = 4'b1101;
  localparam logic [3:0] OP_LEA = 4'b1110;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_EXEC2  = 3'd3,
    S_PAUSE  = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  localparam logic [1:0] ADDR_PC  = 2'd0;
  localparam logic [1:0] ADDR_ALU = 2'd1;
  localparam logic [1:0] ADDR_MDR = 2'd2;

  localparam logic [1:0] PC_INC   = 2'd0;
  localparam logic [1:0] PC_ALU   = 2'd1;
  localparam logic [1:0] PC_BASER = 2'd2;

  localparam logic WA_DR = 1'b0;
  localparam logic WA_R7 = 1'b1;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;

  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_AND  = 2'd1;
  localparam logic [1:0] ALU_PASS = 2'd2;
  localparam logic [1:0] ALU_NOT  = 2'd3;

  localparam logic A_SR1 = 1'b0;
  localparam logic A_PC  = 1'b1;

  localparam logic [2:0] B_SR2   = 3'd0;
  localparam logic [2:0] B_IMM5  = 3'd1;
  localparam logic [2:0] B_OFF9  = 3'd2;
  localparam logic [2:0] B_OFF11 = 3'd3;
  localparam logic [2:0] B_OFF6  = 3'd4;

  // Branch is taken when any requested condition code is currently set.
  function automatic logic br_taken(input logic [2:0] nzp, input logic [2:0] cc);
    return |(nzp & cc);
  endfunction

endpackage

// File: rtl/punc_wait_timer.sv
// rtl/punc_wait_timer.sv - counts consecutive stalled memory cycles and flags the timeout limit
module punc_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic wait_cyc,
  input  logic clr,
  output logic limit_hit
);

  // limit_hit marks the cycle that would become the TIMEOUT-th consecutive wait.
  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr || !wait_cyc) begin
      cnt <= '0;
    end else if (cnt != 8'hFF) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign limit_hit = (cnt == LIMIT);

endmodule

// File: rtl/punc_control_hs.sv
// rtl/punc_control_hs.sv - multicycle control FSM with memory handshake, single-step and timeout fault
module punc_control_hs
  import punc_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15,
  parameter int STEP_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ir,
  input  logic              cc_n,
  input  logic              cc_z,
  input  logic              cc_p,
  input  logic              mem_ack,
  input  logic              step,
  input  logic              go,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_addr_sel,
  output logic              ir_ld,
  output logic              pc_ld,
  output logic              reg_we,
  output logic              cc_ld,
  output logic              mdr_ld,
  output logic [1:0]        pc_sel,
  output logic              reg_waddr_sel,
  output logic [1:0]        reg_wdata_sel,
  output logic [1:0]        alu_op,
  output logic              alu_a_sel,
  output logic [2:0]        alu_b_sel,
  output logic [2:0]        state_o,
  output logic              halted,
  output logic              fault
);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] opc;
  logic       step_on;
  logic       done;
  logic       wait_hit;
  logic       unused_in;

  assign opc       = ir[15:12];
  assign unused_in = ^{ir, step};

  generate
    if (STEP_EN != 0) begin : g_step
      assign step_on = step;
    end else begin : g_nostep
      assign step_on = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    done          = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr_sel  = ADDR_PC;
    ir_ld         = 1'b0;
    pc_ld         = 1'b0;
    reg_we        = 1'b0;
    cc_ld         = 1'b0;
    mdr_ld        = 1'b0;
    pc_sel        = PC_INC;
    reg_waddr_sel = WA_DR;
    reg_wdata_sel = WD_ALU;
    alu_op        = ALU_ADD;
    alu_a_sel     = A_SR1;
    alu_b_sel     = B_SR2;
    halted        = 1'b0;
    fault         = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req      = 1'b1;
        mem_addr_sel = ADDR_PC;
        ir_ld        = mem_ack;
        if (mem_ack) state_d = S_DECODE;
      end
      S_DECODE: begin
        pc_ld   = 1'b1;
        pc_sel  = PC_INC;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (opc)
          OP_ADD, OP_AND, OP_NOT: begin
            reg_we    = 1'b1;
            cc_ld     = 1'b1;
            alu_op    = (opc == OP_ADD) ? ALU_ADD : (opc == OP_AND) ? ALU_AND : ALU_NOT;
            alu_b_sel = ir[5] ? B_IMM5 : B_SR2;
            done      = 1'b1;
          end
          OP_LEA: begin
            reg_we    = 1'b1;
            cc_ld     = 1'b1;
            alu_a_sel = A_PC;
            alu_b_sel = B_OFF9;
            done      = 1'b1;
          end
          OP_BR: begin
            if (br_taken(ir[11:9], {cc_n, cc_z, cc_p})) begin
              pc_ld     = 1'b1;
              pc_sel    = PC_ALU;
              alu_a_sel = A_PC;
              alu_b_sel = B_OFF9;
            end
            done = 1'b1;
          end
          OP_JMP: begin
            pc_ld  = 1'b1;
            pc_sel = PC_BASER;
            done   = 1'b1;
          end
          OP_JSR: begin
            reg_we        = 1'b1;
            reg_waddr_sel = WA_R7;
            reg_wdata_sel = WD_PC;
            state_d       = S_EXEC2;
          end
          OP_LD, OP_LDR: begin
            mem_req       = 1'b1;
            mem_addr_sel  = ADDR_ALU;
            alu_a_sel     = (opc == OP_LD) ? A_PC : A_SR1;
            alu_b_sel     = (opc == OP_LD) ? B_OFF9 : B_OFF6;
            reg_wdata_sel = WD_MEM;
            reg_we        = mem_ack;
            cc_ld         = mem_ack;
            done          = mem_ack;
          end
          OP_ST, OP_STR: begin
            mem_req      = 1'b1;
            mem_we       = 1'b1;
            mem_addr_sel = ADDR_ALU;
            alu_a_sel    = (opc == OP_ST) ? A_PC : A_SR1;
            alu_b_sel    = (opc == OP_ST) ? B_OFF9 : B_OFF6;
            done         = mem_ack;
          end
          OP_LDI, OP_STI: begin
            mem_req      = 1'b1;
            mem_addr_sel = ADDR_ALU;
            alu_a_sel    = A_PC;
            alu_b_sel    = B_OFF9;
            mdr_ld       = mem_ack;
            if (mem_ack) state_d = S_EXEC2;
          end
          OP_HLT: state_d = S_HALT;
          default: done = 1'b1;
        endcase
      end
      S_EXEC2: begin
        case (opc)
          OP_JSR: begin
            pc_ld = 1'b1;
            if (ir[11]) begin
              pc_sel    = PC_ALU;
              alu_a_sel = A_PC;
              alu_b_sel = B_OFF11;
            end else begin
              pc_sel = PC_BASER;
            end
            done = 1'b1;
          end
          OP_LDI: begin
            mem_req       = 1'b1;
            mem_addr_sel  = ADDR_MDR;
            reg_wdata_sel = WD_MEM;
            reg_we        = mem_ack;
            cc_ld         = mem_ack;
            done          = mem_ack;
          end
          OP_STI: begin
            mem_req      = 1'b1;
            mem_we       = 1'b1;
            mem_addr_sel = ADDR_MDR;
            done         = mem_ack;
          end
          default: done = 1'b1;
        endcase
      end
      S_PAUSE: begin
        if (go) state_d = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        if (go) state_d = S_FETCH;
      end
      S_FAULT: fault = 1'b1;
      default: state_d = S_FETCH;
    endcase

    if (done) state_d = step_on ? S_PAUSE : S_FETCH;
    // A late ack still beats the timeout because the fault only applies while unacknowledged.
    if (mem_req && !mem_ack && wait_hit) state_d = S_FAULT;
  end

  punc_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .wait_cyc (mem_req & ~mem_ack),
    .clr      (state_d != state_q),
    .limit_hit(wait_hit)
  );

  assign state_o = state_q;

endmodule

// File: tb/tb_punc_control_hs.sv
// tb/tb_punc_control_hs.sv - randomized and directed bench for punc_control_hs against a phase-plan model
module tb_punc_control_hs;

  localparam int TIMEOUT = 15;

  typedef struct packed {
    logic       req;
    logic       we;
    logic [1:0] asel;
    logic       ir_ld;
    logic       pc_ld;
    logic       reg_we;
    logic       cc_ld;
    logic       mdr_ld;
    logic [1:0] pc_sel;
    logic       waddr;
    logic [1:0] wdata;
    logic [1:0] alu_op;
    logic       a_sel;
    logic [2:0] b_sel;
    logic       halted;
    logic       fault;
  } outs_t;

  localparam int M_RUN = 0, M_PAUSE = 1, M_HALT = 2, M_FAULT = 3;

  logic clk = 1'b0;
  logic rst, cc_n, cc_z, cc_p, mem_ack, step, go;
  logic [15:0] ir;
  logic mem_req, mem_we, ir_ld, pc_ld, reg_we, cc_ld, mdr_ld, reg_waddr_sel, alu_a_sel, halted, fault;
  logic [1:0] mem_addr_sel, pc_sel, reg_wdata_sel, alu_op;
  logic [2:0] alu_b_sel, state_o;

  int n_chk = 0;
  int n_bad = 0;
  int m_mode = M_RUN;
  int m_p = 0;
  int m_wait = 0;
  outs_t ph[4];
  int ph_n;
  bit ph_hlt;

  always #5 clk = ~clk;

  punc_control_hs dut (
    .clk(clk), .rst(rst), .ir(ir), .cc_n(cc_n), .cc_z(cc_z), .cc_p(cc_p),
    .mem_ack(mem_ack), .step(step), .go(go), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_ld(ir_ld), .pc_ld(pc_ld), .reg_we(reg_we),
    .cc_ld(cc_ld), .mdr_ld(mdr_ld), .pc_sel(pc_sel), .reg_waddr_sel(reg_waddr_sel),
    .reg_wdata_sel(reg_wdata_sel), .alu_op(alu_op), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .state_o(state_o), .halted(halted), .fault(fault)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Per-instruction list of phases: fetch, decode, then one or two execute phases.
  task automatic plan(input logic [15:0] i, input logic [2:0] cc);
    logic [3:0] op;
    op = i[15:12];
    for (int k = 0; k < 4; k++) ph[k] = '0;
    ph_n = 3;
    ph_hlt = 1'b0;
    ph[0].req = 1'b1;
    ph[0].ir_ld = 1'b1;
    ph[1].pc_ld = 1'b1;
    case (op)
      4'd1, 4'd5, 4'd9: begin
        ph[2].reg_we = 1'b1; ph[2].cc_ld = 1'b1;
        ph[2].alu_op = (op == 4'd1) ? 2'd0 : (op == 4'd5) ? 2'd1 : 2'd3;
        ph[2].b_sel = i[5] ? 3'd1 : 3'd0;
      end
      4'd14: begin
        ph[2].reg_we = 1'b1; ph[2].cc_ld = 1'b1; ph[2].a_sel = 1'b1; ph[2].b_sel = 3'd2;
      end
      4'd0: if ((i[11] & cc[2]) | (i[10] & cc[1]) | (i[9] & cc[0])) begin
        ph[2].pc_ld = 1'b1; ph[2].pc_sel = 2'd1; ph[2].a_sel = 1'b1; ph[2].b_sel = 3'd2;
      end
      4'd12: begin
        ph[2].pc_ld = 1'b1; ph[2].pc_sel = 2'd2;
      end
      4'd4: begin
        ph_n = 4;
        ph[2].reg_we = 1'b1; ph[2].waddr = 1'b1; ph[2].wdata = 2'd2;
        ph[3].pc_ld = 1'b1; ph[3].pc_sel = i[11] ? 2'd1 : 2'd2;
        if (i[11]) begin ph[3].a_sel = 1'b1; ph[3].b_sel = 3'd3; end
      end
      4'd2, 4'd6: begin
        ph[2].req = 1'b1; ph[2].asel = 2'd1; ph[2].wdata = 2'd1;
        ph[2].reg_we = 1'b1; ph[2].cc_ld = 1'b1;
        ph[2].a_sel = (op == 4'd2); ph[2].b_sel = (op == 4'd2) ? 3'd2 : 3'd4;
      end
      4'd3, 4'd7: begin
        ph[2].req = 1'b1; ph[2].we = 1'b1; ph[2].asel = 2'd1;
        ph[2].a_sel = (op == 4'd3); ph[2].b_sel = (op == 4'd3) ? 3'd2 : 3'd4;
      end
      4'd10, 4'd11: begin
        ph_n = 4;
        ph[2].req = 1'b1; ph[2].asel = 2'd1; ph[2].a_sel = 1'b1; ph[2].b_sel = 3'd2; ph[2].mdr_ld = 1'b1;
        ph[3].req = 1'b1; ph[3].asel = 2'd2;
        if (op == 4'd10) begin ph[3].wdata = 2'd1; ph[3].reg_we = 1'b1; ph[3].cc_ld = 1'b1; end
        else ph[3].we = 1'b1;
      end
      4'd13: ph_hlt = 1'b1;
      default: ;
    endcase
  endtask

  task automatic cycle(input logic [15:0] i, input logic [2:0] cc, input logic a, input logic s,
                       input logic g, input logic r);
    outs_t e, got;
    int sc;
    @(posedge clk);
    #1;
    ir = i; {cc_n, cc_z, cc_p} = cc; mem_ack = a; step = s; go = g; rst = r;
    @(negedge clk);
    plan(i, cc);
    e = '0;
    sc = 6;
    case (m_mode)
      M_RUN: begin
        e = ph[m_p];
        if (e.req) begin
          e.ir_ld &= a; e.reg_we &= a; e.cc_ld &= a; e.mdr_ld &= a;
        end
        sc = m_p;
      end
      M_PAUSE: sc = 4;
      M_HALT: begin e.halted = 1'b1; sc = 5; end
      default: begin e.fault = 1'b1; sc = 6; end
    endcase
    got = {mem_req, mem_we, mem_addr_sel, ir_ld, pc_ld, reg_we, cc_ld, mdr_ld, pc_sel,
           reg_waddr_sel, reg_wdata_sel, alu_op, alu_a_sel, alu_b_sel, halted, fault};
    chk("outputs", 32'(got), 32'(e));
    chk("state", 32'(state_o), 32'(sc));
    if (r) begin
      m_mode = M_RUN; m_p = 0; m_wait = 0;
    end else begin
      case (m_mode)
        M_RUN: begin
          if (ph[m_p].req && !a) begin
            m_wait++;
            if (m_wait == TIMEOUT) begin m_mode = M_FAULT; m_wait = 0; end
          end else begin
            m_wait = 0;
            m_p++;
            if (m_p == ph_n) begin
              m_p = 0;
              if (ph_hlt) m_mode = M_HALT;
              else if (s) m_mode = M_PAUSE;
            end
          end
        end
        M_PAUSE, M_HALT: if (g) begin m_mode = M_RUN; m_p = 0; end
        default: ;
      endcase
    end
  endtask

  initial begin
    int mdr_p, we_p, ex_req;
    logic [12:0] ap;
    logic [15:0] ri;
    rst = 1'b1; ir = '0; cc_n = 0; cc_z = 0; cc_p = 0; mem_ack = 0; step = 0; go = 0;
    repeat (2) @(posedge clk);

    cycle(16'h0000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_req", 32'(mem_req), 32'd1);
    chk("reset_state", 32'(state_o), 32'd0);
    chk("reset_irld", 32'(ir_ld), 32'd0);

    cycle(16'h0000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(16'h12A3, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("add_irld", 32'(ir_ld), 32'd1);
    cycle(16'h12A3, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("add_decode", 32'(state_o), 32'd1);
    cycle(16'h12A3, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("add_exec", 32'({reg_we, cc_ld, alu_b_sel}), 32'({1'b1, 1'b1, 3'd1}));
    cycle(16'h12A3, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("add_back", 32'(state_o), 32'd0);

    cycle(16'h0000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    ap = 13'b1000100001000;
    mdr_p = 0; we_p = 0; ex_req = 0;
    for (int k = 0; k < 13; k++) begin
      cycle(16'hA205, 3'b000, ap[k], 1'b0, 1'b0, 1'b0);
      mdr_p += int'(mdr_ld);
      we_p += int'(reg_we);
      ex_req += int'(mem_req && state_o == 3'd2);
    end
    chk("ldi_mdr_pulses", 32'(mdr_p), 32'd1);
    chk("ldi_we_pulses", 32'(we_p), 32'd1);
    chk("ldi_exec_req_len", 32'(ex_req), 32'd4);
    cycle(16'hA205, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ldi_back", 32'(state_o), 32'd0);

    cycle(16'h0000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= TIMEOUT; k++) cycle(16'h0000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("to_last_wait", 32'(state_o), 32'd0);
    cycle(16'h0000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("to_fault", 32'({state_o, fault}), 32'({3'd6, 1'b1}));
    cycle(16'h0000, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(16'h0000, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("to_stuck", 32'({state_o, fault}), 32'({3'd6, 1'b1}));
    cycle(16'h0000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(16'h0000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("to_rst", 32'({state_o, fault}), 32'({3'd0, 1'b0}));

    cycle(16'h0000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) cycle(16'h0405, 3'b000, k == 0, 1'b0, 1'b0, 1'b0);
    chk("brz_not", 32'(pc_ld), 32'd0);
    for (int k = 0; k < 3; k++) cycle(16'h0405, 3'b010, k == 0, 1'b0, 1'b0, 1'b0);
    chk("brz_taken", 32'({pc_ld, pc_sel}), 32'({1'b1, 2'd1}));

    cycle(16'h0000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) cycle(16'h12A3, 3'b000, k == 0, 1'b1, 1'b0, 1'b0);
    cycle(16'h12A3, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("step_pause", 32'(state_o), 32'd4);
    cycle(16'hD000, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cycle(16'hD000, 3'b000, k == 0, 1'b1, 1'b0, 1'b0);
    cycle(16'hD000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("hlt_halted", 32'({state_o, halted}), 32'({3'd5, 1'b1}));
    cycle(16'hD000, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle(16'hD000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("hlt_resume", 32'({state_o, halted}), 32'({3'd0, 1'b0}));

    cycle(16'h0000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(16'hB205, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(16'hB205, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(16'hB205, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(16'hB205, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("sti_exec2_we", 32'({state_o, mem_req, mem_we}), 32'({3'd3, 1'b1, 1'b1}));
    cycle(16'hB205, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sti_rst", 32'({state_o, mem_we}), 32'({3'd0, 1'b0}));

    ri = 16'h0000;
    for (int k = 0; k < 3000; k++) begin
      if (m_mode != M_RUN || m_p == 0) ri = 16'($urandom);
      cycle(ri, 3'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 299) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/punc_control_hs.md
PUNC_CONTROL_HS -- requirements
Module: punc_control_hs

Interface
REQ-001 Parameter DATA_W, default 16, instruction/datapath width; SHALL be at least 16.
REQ-002 Parameter TIMEOUT, default 15, maximum cycles a memory request may wait for mem_ack before FAULT; range 1..255.
REQ-003 Parameter STEP_EN, default 1; when 0, single-step logic SHALL be absent and step SHALL be ignored.
REQ-004 Ports, listed as name, direction, width, meaning; one clock; reset is synchronous and active-high:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ir  in  DATA_W  instruction register contents
- cc_n, cc_z, cc_p  in  1 each  current condition codes
- mem_ack  in  1  memory completes the current request this cycle
- step  in  1  single-step mode enable
- go  in  1  pulse; resumes from PAUSE or HALT
- mem_req, mem_we  out  1 each  memory request, write qualifier
- mem_addr_sel  out  2  0 PC, 1 ALU, 2 MDR
- ir_ld, pc_ld, reg_we, cc_ld, mdr_ld  out  1 each  load enables
- pc_sel  out  2  0 PC+1, 1 ALU, 2 BaseR
- reg_waddr_sel  out  1  0 DR, 1 R7
- reg_wdata_sel  out  2  0 ALU, 1 MEM, 2 PC
- alu_op  out  2  0 ADD, 1 AND, 2 PASS, 3 NOT
- alu_a_sel  out  1  0 SR1, 1 PC
- alu_b_sel  out  3  0 SR2, 1 imm5, 2 off9, 3 off11, 4 off6
- state_o  out  3  current state encoding
- halted, fault  out  1 each  status flags

Function
REQ-005 States: FETCH, DECODE, EXEC, EXEC2, PAUSE, HALT, FAULT; all outputs SHALL be a combinational function of the state, ir, cc_*, and mem_ack.
REQ-006 Every output not driven by a state SHALL be 0.
REQ-007 FETCH: mem_req=1, mem_addr_sel=0, ir_ld=mem_ack; on mem_ack go to DECODE, otherwise remain in FETCH.
REQ-008 DECODE: pc_ld=1, pc_sel=0; next state EXEC.
REQ-009 In any memory-access state, all control outputs SHALL be held stable while mem_ack=0.
REQ-010 In a memory-access state, register, cc, and MDR enables SHALL be gated by mem_ack.
REQ-011 EXEC for ADD/AND/NOT: reg_we=1, cc_ld=1, alu_op per opcode, alu_b_sel=imm5 when ir[5]=1.
REQ-012 EXEC for LEA: reg_we=1, cc_ld=1, alu_a_sel=PC, alu_b_sel=off9.
REQ-013 BR: pc_ld=1, pc_sel=ALU, alu_a_sel=PC, alu_b_sel=off9 only if (ir[11]&cc_n)|(ir[10]&cc_z)|(ir[9]&cc_p).
REQ-014 JMP: pc_ld=1, pc_sel=BaseR.
REQ-015 JSR/JSRR: EXEC writes R7 with PC (reg_waddr_sel=1, reg_wdata_sel=2).
REQ-016 JSR/JSRR: EXEC2 loads PC from ALU (PC+off11) if ir[11]=1, else from BaseR.
REQ-017 LD/LDR: a memory read through the ALU address path; reg_wdata_sel=MEM, reg_we and cc_ld gated by mem_ack.
REQ-018 ST/STR: mem_we=1 to the ALU address.
REQ-019 LDI/STI: EXEC reads the pointer into MDR (mdr_ld on ack); EXEC2 reads or writes at mem_addr_sel=MDR.
REQ-020 Opcode HLT (4'b1101) SHALL go to HALT with halted=1.
REQ-021 In HALT, go=1 SHALL return to FETCH.
REQ-022 Completion of EXEC/EXEC2 SHALL go to FETCH, or to PAUSE when STEP_EN=1 and step=1.
REQ-023 In PAUSE, go=1 SHALL go to FETCH.
REQ-024 An 8-bit wait counter SHALL count consecutive cycles with mem_req=1 and mem_ack=0, and SHALL clear on ack or on a state change.
REQ-025 If the wait counter reaches TIMEOUT, the next state SHALL be FAULT.
REQ-026 FAULT: fault=1, all enables 0, stays in FAULT until rst.
REQ-027 If mem_ack and timeout occur in the same cycle, the ack SHALL win.
REQ-028 If go is asserted outside PAUSE/HALT, it SHALL be ignored.
REQ-029 Unused opcodes (RTI 4'b1000) SHALL behave as NOP and return to FETCH.

Reset
REQ-030 When rst=1 at a clk edge, the state SHALL become FETCH and the wait counter 0, regardless of current state, including FAULT or mid-handshake.
REQ-031 After reset, outputs SHALL be mem_req=1, ir_ld=mem_ack, state_o=0, and all other outputs 0.

Structure
REQ-032 Shared package punc_pkg SHALL hold the opcode constants, state encodings, and all select encodings.
REQ-033 The wait counter with timeout compare SHALL be sub-module punc_wait_timer.

Verification
REQ-034 ADD R1,R2,#3 (0x12A3), mem_ack asserted on the first cycle of FETCH: FETCH→DECODE→EXEC→FETCH in 3 cycles; reg_we=1, cc_ld=1, alu_b_sel=1 during EXEC.
REQ-035 LDI with mem_ack delayed 3 cycles on each access: each mem_req is held for 4 cycles; mdr_ld pulses once in EXEC; reg_we pulses once in EXEC2.
REQ-036 mem_ack never asserted, TIMEOUT=15: FAULT is entered after 15 wait cycles; fault=1 until rst; rst returns to FETCH.
REQ-037 BRz with cc_z=0 then cc_z=1: pc_ld=0 in the first case and pc_ld=1 with pc_sel=1 in the second.
REQ-038 step=1, ADD followed by HLT: PAUSE after the ADD; go moves to FETCH; HLT gives halted=1; go resumes to FETCH.
REQ-039 rst asserted during STI EXEC2 with mem_req high: FETCH on the next cycle; mem_we=0 in that cycle.
